// File: rtl/datamemory_copier.sv
// datamemory_copier: block-copy requester for the single-port data memory.
// Each word is read, held for one cycle while the memory's registered output
// settles, and then written before the next read starts. Because of that
// ordering, overlapping copies give a deterministic result. Every output is
// driven by a register. The combinational process computes the value each
// output should take in the state being entered.
module datamemory_copier #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] sum,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] src_q, src_n;
  logic [ADDR_W-1:0] dst_q, dst_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic [ADDR_W:0]   idx_q, idx_n;
  logic [DATA_W-1:0] data_q, data_n;

  logic              busy_n;
  logic              done_n;
  logic [ADDR_W:0]   count_n;
  logic [DATA_W-1:0] sum_n;
  logic              ce_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n;

  logic [ADDR_W:0]   idx_plus;

  // The index after the current word. It decides whether another word remains.
  assign idx_plus = idx_q + 1'b1;

  // Register the FSM state, the latched request, and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      sum         <= '0;
      mem_ce      <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= '0;
    end else begin
      state       <= state_n;
      src_q       <= src_n;
      dst_q       <= dst_n;
      len_q       <= len_n;
      idx_q       <= idx_n;
      data_q      <= data_n;
      busy        <= busy_n;
      done        <= done_n;
      count       <= count_n;
      sum         <= sum_n;
      mem_ce      <= ce_n;
      mem_we      <= we_n;
      mem_address <= addr_n;
      mem_dataIn  <= din_n;
    end
  end

  // Compute the next state and the output values that go with the state being entered.
  always_comb begin
    state_n = state;
    src_n   = src_q;
    dst_n   = dst_q;
    len_n   = len_q;
    idx_n   = idx_q;
    data_n  = data_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    count_n = count;
    sum_n   = sum;
    ce_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = mem_address;
    din_n   = mem_dataIn;

    unique case (state)
      IDLE: begin
        if (start) begin
          src_n   = src;
          dst_n   = dst;
          len_n   = len;
          idx_n   = '0;
          count_n = '0;
          sum_n   = '0;
          if (len == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RD;
            busy_n  = 1'b1;
            ce_n    = 1'b1;
            addr_n  = src;
          end
        end
      end

      RD: begin
        state_n = LAT;
        busy_n  = 1'b1;
      end

      LAT: begin
        // The read result is captured here. The memory clears its output
        // on this same edge, which does not affect the captured value.
        // The same value goes directly to the write-data register.
        data_n  = mem_dataOut;
        state_n = WR;
        busy_n  = 1'b1;
        ce_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = dst_q + idx_q[ADDR_W-1:0];
        din_n   = mem_dataOut;
      end

      WR: begin
        count_n = count + 1'b1;
        sum_n   = sum + data_q;
        idx_n   = idx_plus;
        if (idx_plus < len_q) begin
          state_n = RD;
          busy_n  = 1'b1;
          ce_n    = 1'b1;
          addr_n  = src_q + idx_plus[ADDR_W-1:0];
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
